// File: rtl/prog_counter.sv
// Loop-aware program counter for a bracket-style interpreter: sequences fetch
// addresses, keeps a loop-return stack, and skips over loop bodies whose guard cell is zero.
//
// state | meaning
// IDLE  | waiting for Start after reset
// RUN   | executing; one PC step per non-stalled cycle
// SKIP  | scanning forward past a zero-guarded loop body, counting nesting
// DONE  | halted normally (Halt or end of address space in RUN)
// ERR   | halted on error; ErrCode holds the cause
module prog_counter #(
    parameter int IW = 16,
    parameter int SD = 8,
    localparam int DW = $clog2(SD + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          LoopOpen,
    input  logic          LoopClose,
    input  logic          Halt,
    input  logic          CellZero,
    output logic [IW-1:0] InstAddress,
    output logic          Running,
    output logic          Done,
    output logic          Error,
    output logic [1:0]    ErrCode,
    output logic [DW-1:0] Depth
);

    localparam int AW = (SD > 1) ? $clog2(SD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SKIP,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [IW-1:0] skip_q, skip_d;
    logic [1:0]    err_q, err_d;
    logic          running_q, done_q, error_q;
    logic          push;

    logic [IW-1:0] stack_q [SD];

    logic          pc_last;
    logic          stack_full;
    logic          stack_empty;
    logic [IW-1:0] stack_top;

    assign pc_last     = &pc_q;
    assign stack_full  = (depth_q == DW'(SD));
    assign stack_empty = (depth_q == '0);
    assign stack_top   = stack_q[AW'(depth_q - DW'(1))];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        skip_d  = skip_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = StartAddr;
                    depth_d = '0;
                    skip_d  = '0;
                    err_d   = 2'd0;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    if (LoopOpen && LoopClose) begin
                        state_d = S_ERR;
                        err_d   = 2'd3;
                    end else if (Halt) begin
                        state_d = S_DONE;
                    end else if (LoopOpen && !CellZero && stack_full) begin
                        state_d = S_ERR;
                        err_d   = 2'd1;
                    end else if (LoopClose && stack_empty) begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end else if (LoopClose && !CellZero) begin
                        pc_d = stack_top + 1'b1;
                    end else if (pc_last) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
                        if (LoopOpen) begin
                            if (CellZero) begin
                                skip_d  = IW'(1);
                                state_d = S_SKIP;
                            end else begin
                                push    = 1'b1;
                                depth_d = depth_q + 1'b1;
                            end
                        end else if (LoopClose) begin
                            depth_d = depth_q - 1'b1;
                        end
                    end
                end
            end
            S_SKIP: begin
                // Halt and CellZero are deliberately ignored while skipping.
                if (!Stall) begin
                    if ((LoopOpen && LoopClose) || pc_last) begin
                        state_d = S_ERR;
                        err_d   = 2'd3;
                    end else begin
                        pc_d = pc_q + 1'b1;
                        if (LoopOpen) begin
                            skip_d = skip_q + 1'b1;
                        end else if (LoopClose) begin
                            skip_d = skip_q - 1'b1;
                            if (skip_q == IW'(1)) begin
                                state_d = S_RUN;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            depth_q   <= '0;
            skip_q    <= '0;
            err_q     <= 2'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            skip_q    <= skip_d;
            err_q     <= err_d;
            running_q <= (state_d == S_RUN) || (state_d == S_SKIP);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERR);
        end
    end

    // Stack storage is never cleared; Depth alone decides what is reachable.
    always_ff @(posedge Clk) begin
        if (Reset && push) begin
            stack_q[AW'(depth_q)] <= pc_q;
        end
    end

    assign InstAddress = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign Error       = error_q;
    assign ErrCode     = err_q;
    assign Depth       = depth_q;

endmodule
